// File: rtl/b01_pkg.sv
// Shared types for the b01 serial add scheduler.
// FSM encoding, default width and the response bundle.
package b01_pkg;

  localparam int unsigned B01_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic                 id;
    logic [B01_WIDTH-1:0] sum;
    logic                 overflw;
  } rsp_t;

endpackage

// File: rtl/b01_serial_core.sv
// Bit-serial full adder: carry and bit index registers.
// State vector {carry, index} mirrors the original b01 state.
module b01_serial_core
  import b01_pkg::*;
#(
  parameter int unsigned WIDTH = B01_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line1,
  input  logic line2,
  input  logic clear,
  input  logic enable,
  output logic outp,
  output logic carry,
  output logic last
);

  logic          carry_q, carry_d;
  logic [CW-1:0] idx_q, idx_d;

  always_comb begin
    outp    = line1 ^ line2 ^ carry_q;
    carry   = (line1 & line2) | (line1 & carry_q) | (line2 & carry_q);
    last    = (idx_q == CW'(WIDTH - 1));
    carry_d = carry_q;
    idx_d   = idx_q;
    if (clear) begin
      carry_d = 1'b0;
      idx_d   = '0;
    end else if (enable) begin
      carry_d = carry;
      idx_d   = idx_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/b01_serial_sched.sv
// Two-requester round-robin front end for the shared
// bit-serial adder core, with a valid/ready response port.
module b01_serial_sched
  import b01_pkg::*;
#(
  parameter int unsigned WIDTH = B01_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH)
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             REQ0_VALID,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  output logic             REQ0_READY,
  input  logic             REQ1_VALID,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  output logic             REQ1_READY,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_SUM,
  output logic             RSP_OVERFLW,
  output logic             LINE1,
  output logic             LINE2,
  output logic             OUTP
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] sum_q, sum_d;
  logic             id_q, id_d;
  rsp_t             rsp_q, rsp_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             last_gnt_q, last_gnt_d;

  logic idle, shifting, accept;
  logic grant0, grant1;
  logic outp, carry, last;

  assign idle     = (state_q == IDLE);
  assign shifting = (state_q == SHIFT);

  // On a tie the requester that did not own the last response wins.
  assign grant0 = REQ0_VALID & (~REQ1_VALID | last_gnt_q);
  assign grant1 = REQ1_VALID & (~REQ0_VALID | ~last_gnt_q);

  assign REQ0_READY = RESET_N & idle & grant0;
  assign REQ1_READY = RESET_N & idle & grant1;

  assign LINE1 = shifting & a_q[0];
  assign LINE2 = shifting & b_q[0];
  assign OUTP  = shifting & outp;

  assign RSP_VALID   = rsp_valid_q;
  assign RSP_ID      = rsp_q.id;
  assign RSP_SUM     = rsp_q.sum;
  assign RSP_OVERFLW = rsp_q.overflw;

  b01_serial_core #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_core (
    .clk    (CLOCK),
    .rst_n  (RESET_N),
    .line1  (LINE1),
    .line2  (LINE2),
    .clear  (accept),
    .enable (shifting),
    .outp   (outp),
    .carry  (carry),
    .last   (last)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    id_d        = id_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    last_gnt_d  = last_gnt_q;
    accept      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          accept  = 1'b1;
          id_d    = grant1;
          a_d     = grant1 ? REQ1_A : REQ0_A;
          b_d     = grant1 ? REQ1_B : REQ0_B;
          sum_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Sum bits enter at the top so the first bit lands at the LSB.
        sum_d = (WIDTH - 1)'({outp, sum_q} >> 1);
        if (last) begin
          rsp_d.id      = id_q;
          rsp_d.sum     = {outp, sum_q};
          rsp_d.overflw = carry;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          last_gnt_d  = rsp_q.id;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      id_q        <= 1'b0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      last_gnt_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      id_q        <= id_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

endmodule

// File: tb/tb_b01_serial_sched.sv
// Directed bench for b01_serial_sched: vector table plus
// hand-written contention, backpressure, reset and idle sequences.
module tb_b01_serial_sched;

  localparam int W = 4;

  logic         CLOCK = 1'b0;
  logic         RESET_N;
  logic         REQ0_VALID, REQ1_VALID;
  logic [W-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic         REQ0_READY, REQ1_READY;
  logic         RSP_VALID, RSP_READY, RSP_ID, RSP_OVERFLW;
  logic [W-1:0] RSP_SUM;
  logic         LINE1, LINE2, OUTP;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         ovf;
  } vec_t;

  vec_t tbl [8];

  b01_serial_sched dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .REQ0_VALID  (REQ0_VALID),
    .REQ0_A      (REQ0_A),
    .REQ0_B      (REQ0_B),
    .REQ0_READY  (REQ0_READY),
    .REQ1_VALID  (REQ1_VALID),
    .REQ1_A      (REQ1_A),
    .REQ1_B      (REQ1_B),
    .REQ1_READY  (REQ1_READY),
    .RSP_VALID   (RSP_VALID),
    .RSP_READY   (RSP_READY),
    .RSP_ID      (RSP_ID),
    .RSP_SUM     (RSP_SUM),
    .RSP_OVERFLW (RSP_OVERFLW),
    .LINE1       (LINE1),
    .LINE2       (LINE2),
    .OUTP        (OUTP)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic next();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic rdy(input logic id);
    return id ? REQ1_READY : REQ0_READY;
  endfunction

  function automatic logic [31:0] all_out();
    return 32'({REQ0_READY, REQ1_READY, RSP_VALID, RSP_ID,
                RSP_SUM, RSP_OVERFLW, LINE1, LINE2, OUTP});
  endfunction

  task automatic wait_ready(input logic id, input string name);
    int k = 0;
    @(negedge CLOCK);
    while (!rdy(id) && k < 20) begin
      @(negedge CLOCK);
      k++;
    end
    chk(name, 32'(rdy(id)), 32'd1);
  endtask

  task automatic wait_rsp(input string name);
    int k = 0;
    @(negedge CLOCK);
    while (!RSP_VALID && k < 30) begin
      @(negedge CLOCK);
      k++;
    end
    chk(name, 32'(RSP_VALID), 32'd1);
  endtask

  task automatic drive(input logic id, input logic v,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (id) begin
      REQ1_VALID = v; REQ1_A = a; REQ1_B = b;
    end else begin
      REQ0_VALID = v; REQ0_A = a; REQ0_B = b;
    end
  endtask

  task automatic run_txn(input vec_t v, input int n);
    logic [W-1:0] l1, l2, o;
    drive(v.id, 1'b1, v.a, v.b);
    wait_ready(v.id, $sformatf("v%0d_accept", n));
    next();
    drive(v.id, 1'b0, '0, '0);
    for (int i = 0; i < W; i++) begin
      @(negedge CLOCK);
      l1[i] = LINE1;
      l2[i] = LINE2;
      o[i]  = OUTP;
      if (i == W - 1)
        chk($sformatf("v%0d_lat_pre", n), 32'(RSP_VALID), 32'd0);
    end
    @(negedge CLOCK);
    chk($sformatf("v%0d_valid", n), 32'(RSP_VALID), 32'd1);
    chk($sformatf("v%0d_sum", n), 32'(RSP_SUM), 32'(v.sum));
    chk($sformatf("v%0d_ovf", n), 32'(RSP_OVERFLW), 32'(v.ovf));
    chk($sformatf("v%0d_id", n), 32'(RSP_ID), 32'(v.id));
    chk($sformatf("v%0d_line1", n), 32'(l1), 32'(v.a));
    chk($sformatf("v%0d_line2", n), 32'(l2), 32'(v.b));
    chk($sformatf("v%0d_outp", n), 32'(o), 32'(v.sum));
    next();
    @(negedge CLOCK);
    chk($sformatf("v%0d_drop", n), 32'(RSP_VALID), 32'd0);
    next();
  endtask

  initial begin : main
    int nrsp;
    int cyc;

    tbl[0] = '{1'b0, 4'd3,  4'd5,  4'd8,  1'b0};
    tbl[1] = '{1'b1, 4'd9,  4'd7,  4'd0,  1'b1};
    tbl[2] = '{1'b1, 4'd15, 4'd15, 4'd14, 1'b1};
    tbl[3] = '{1'b0, 4'd0,  4'd0,  4'd0,  1'b0};
    tbl[4] = '{1'b0, 4'd8,  4'd8,  4'd0,  1'b1};
    tbl[5] = '{1'b1, 4'd6,  4'd9,  4'd15, 1'b0};
    tbl[6] = '{1'b0, 4'd1,  4'd15, 4'd0,  1'b1};
    tbl[7] = '{1'b1, 4'd10, 4'd5,  4'd15, 1'b0};

    RESET_N   = 1'b0;
    RSP_READY = 1'b1;
    drive(1'b0, 1'b1, 4'd3, 4'd3);
    drive(1'b1, 1'b0, '0, '0);
    #1;
    chk("reset_outputs", all_out(), 32'd0);
    next();
    drive(1'b0, 1'b0, '0, '0);
    next();
    RESET_N = 1'b1;
    @(negedge CLOCK);
    chk("post_reset_outputs", all_out(), 32'd0);
    next();

    for (int n = 0; n < 8; n++) run_txn(tbl[n], n);

    // Contention: last owner was requester 1, so 0 goes first.
    drive(1'b0, 1'b1, 4'd2, 4'd3);
    drive(1'b1, 1'b1, 4'd4, 4'd4);
    nrsp = 0;
    cyc  = 0;
    while (nrsp < 4 && cyc < 100) begin
      @(negedge CLOCK);
      cyc++;
      if (RSP_VALID) begin
        chk($sformatf("cont%0d_id", nrsp), 32'(RSP_ID), 32'(nrsp % 2));
        chk($sformatf("cont%0d_sum", nrsp), 32'(RSP_SUM),
            (nrsp % 2) ? 32'd8 : 32'd5);
        nrsp++;
      end
    end
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    chk("cont_count", 32'(nrsp), 32'd4);
    next();

    // Backpressure: 12+7 held for several cycles in RESP.
    RSP_READY = 1'b0;
    drive(1'b1, 1'b1, 4'd12, 4'd7);
    wait_ready(1'b1, "bp_accept");
    next();
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 4'd1, 4'd2);
    wait_rsp("bp_valid");
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("bp%0d_hold", j),
          32'({RSP_VALID, RSP_ID, RSP_SUM, RSP_OVERFLW}),
          32'({1'b1, 1'b1, 4'd3, 1'b1}));
      chk($sformatf("bp%0d_noready", j),
          32'({REQ0_READY, REQ1_READY}), 32'd0);
      @(negedge CLOCK);
    end
    chk("bp_still_valid", 32'(RSP_VALID), 32'd1);
    RSP_READY = 1'b1;
    @(negedge CLOCK);
    chk("bp_released", 32'(RSP_VALID), 32'd0);
    chk("bp_idle_ready", 32'(REQ0_READY), 32'd1);
    next();
    drive(1'b0, 1'b0, '0, '0);
    wait_rsp("bp_next_valid");
    chk("bp_next_id", 32'(RSP_ID), 32'd0);
    chk("bp_next_sum", 32'(RSP_SUM), 32'd3);
    next();

    // Reset in the middle of requester 1's third shift cycle.
    drive(1'b1, 1'b1, 4'd5, 4'd6);
    wait_ready(1'b1, "rst_accept");
    next();
    drive(1'b1, 1'b0, '0, '0);
    next();
    next();
    RESET_N = 1'b0;
    #1;
    chk("rst_outputs", all_out(), 32'd0);
    drive(1'b0, 1'b1, 4'd2, 4'd9);
    drive(1'b1, 1'b1, 4'd7, 4'd7);
    #1;
    chk("rst_ready_gated", all_out(), 32'd0);
    next();
    next();
    RESET_N = 1'b1;
    @(negedge CLOCK);
    chk("rst_fair_r0", 32'(REQ0_READY), 32'd1);
    chk("rst_fair_r1", 32'(REQ1_READY), 32'd0);
    chk("rst_no_rsp", 32'(RSP_VALID), 32'd0);
    next();
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    wait_rsp("rst_next_valid");
    chk("rst_next_id", 32'(RSP_ID), 32'd0);
    chk("rst_next_sum", 32'(RSP_SUM), 32'd11);
    next();

    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK);
      chk($sformatf("idle%0d", i),
          32'({LINE1, LINE2, OUTP, RSP_VALID, REQ0_READY, REQ1_READY}),
          32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/b01_serial_sched.md
Name: b01_serial_sched

Overview:
- Round-robin scheduler that shares one bit-serial adder/overflow core (the b01 datapath: LINE1/LINE2 in, 3-bit state) between two requesters.
- Accepts one parallel operand pair per transaction and shifts it LSB-first through the core, one bit per cycle.
- Assembles the serial sum, then returns sum, overflow flag and requester ID on a valid/ready response port.
- Sits between the request-generating logic and the shared serial comparator/adder resource.

Parameters:
- WIDTH, 4, operand/sum width in bits (≥2); also the number of SHIFT cycles per transaction.
- CW, $clog2(WIDTH), bit-index counter width.

Ports:
- CLOCK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ0_VALID  in  1  requester 0 has an operand pair.
- REQ0_A  in  WIDTH  requester 0 operand A.
- REQ0_B  in  WIDTH  requester 0 operand B.
- REQ0_READY  out  1  requester 0 pair accepted this cycle.
- REQ1_VALID, REQ1_A, REQ1_B, REQ1_READY: same as requester 0, for requester 1.
- RSP_VALID  out  1  result available.
- RSP_READY  in  1  consumer takes the result.
- RSP_ID  out  1  requester that owns the result.
- RSP_SUM  out  WIDTH  (A+B) mod 2^WIDTH.
- RSP_OVERFLW  out  1  carry out of the MSB (unsigned overflow).
- LINE1, LINE2, OUTP  out  1 each  serial observation taps: current A bit, current B bit, current sum bit.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; carry=0; bit index=0; shift regs=0; all outputs 0; LAST_GNT=1, so requester 0 wins the first tie.
- FSM states IDLE, SHIFT, RESP.
- IDLE:
  - Grant rule: if exactly one REQx_VALID, grant it; if both, grant the requester ≠ LAST_GNT.
  - Accept cycle: REQx_READY=1 (combinational, IDLE only) for the granted requester.
  - On accept: capture A, B, ID into registers; carry=0; index=0; go to SHIFT.
  - No request: stay in IDLE.
- SHIFT, one bit per cycle, for exactly WIDTH cycles:
  - LINE1=A[index], LINE2=B[index].
  - OUTP = LINE1^LINE2^carry.
  - carry' = majority(LINE1, LINE2, carry).
  - OUTP is written to sum[index]; index increments.
  - On index==WIDTH-1: register RSP_OVERFLW=carry', go to RESP.
  - REQx_READY=0 throughout.
- RESP:
  - RSP_VALID=1; RSP_SUM, RSP_ID, RSP_OVERFLW held stable until RSP_READY.
  - On RSP_VALID&RSP_READY: LAST_GNT=RSP_ID; go to IDLE. RSP_VALID drops the next cycle.
- Latency: accept at cycle t → RSP_VALID first high at t+WIDTH+1. Throughput is one transaction per WIDTH+2 cycles with RSP_READY tied high.
- Observation taps: LINE1/LINE2/OUTP are 0 outside SHIFT.
- Requester inputs are ignored outside IDLE; a requester holds VALID until it sees READY.
- Reset mid-transaction: the in-flight pair is discarded, no response is produced, and fairness restarts at requester 0.
- Core state encoding, registered: {carry, index[1:0]} for WIDTH=4, matching the 3-bit b01 state vector.

Decomposition:
- Package b01_pkg:
  - FSM state enum (IDLE=2'd0, SHIFT=2'd1, RESP=2'd2).
  - Default WIDTH constant.
  - Response struct {id, sum, overflw}.
- One sub-module b01_serial_core: carry/index registers plus single-bit sum/carry logic. Interface: LINE1, LINE2, clear, enable → OUTP, carry, last.
- Arbitration, operand shifting and the response register stay in the top module.

Test Plan:
- Single add, WIDTH=4: REQ0 A=3, B=5, RSP_READY=1 → REQ0_READY pulses one cycle; OUTP sequence 0,0,0,1; RSP_VALID 5 cycles after accept with SUM=8, OVERFLW=0, ID=0.
- Overflow: REQ1 A=9, B=7 → SUM=0, OVERFLW=1, ID=1. Then A=15, B=15 → SUM=14, OVERFLW=1.
- Contention: both VALID continuously with distinct operands → responses alternate ID 0,1,0,1, starting with 0; no request starves.
- Backpressure: RSP_READY low for 3 cycles in RESP → RSP_VALID/SUM/ID/OVERFLW held stable; no REQx_READY asserted; IDLE is re-entered the cycle after the handshake.
- Reset mid-SHIFT: RESET_N low during bit 2 of REQ1's transaction → all outputs 0 immediately; no response for REQ1. With both VALID after release, requester 0 is granted first.
- Idle: no VALID for 10 cycles → FSM stays in IDLE; LINE1/LINE2/OUTP/RSP_VALID remain 0.
